crypto_issue_ctrl: RTL and testbench



---
 rtl/crypto_issue_ctrl_pkg.sv | 17 +
 rtl/crypto_wb_arb.sv | 37 +++
 rtl/crypto_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_crypto_issue_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_issue_ctrl_pkg.sv
// Shared definitions for the custom-0 encryption issue controller.
//   OPC_CUSTOM0 : major opcode that selects the encryption accelerator
//   CMD_W       : width of the accelerator command {funct7, funct3}
//   state_t     : controller FSM states
package crypto_issue_ctrl_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam int         CMD_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

endpackage

// File: rtl/crypto_wb_arb.sv
// GPR write-port arbiter. The normal pipeline writeback always wins; the
// accelerator result is granted the port only when the pipeline is not
// writing this cycle.
// Ports:
//   alu_wen/alu_sel/alu_data : pipeline writeback request
//   acc_wen/acc_sel/acc_data : accelerator writeback request
//   rf_wen/rf_sel/rf_data    : GPR write port
//   acc_grant                : accelerator request was placed on the port
module crypto_wb_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  alu_wen,
    input  logic [4:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  acc_wen,
    input  logic [4:0]            acc_sel,
    input  logic [DATA_WIDTH-1:0] acc_data,
    output logic                  rf_wen,
    output logic [4:0]            rf_sel,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  acc_grant
);

    always_comb begin
        rf_wen    = alu_wen;
        rf_sel    = alu_sel;
        rf_data   = alu_data;
        acc_grant = 1'b0;
        if (acc_wen && !alu_wen) begin
            rf_wen    = 1'b1;
            rf_sel    = acc_sel;
            rf_data   = acc_data;
            acc_grant = 1'b1;
        end
    end

endmodule

// File: rtl/crypto_issue_ctrl.sv
// Issue controller for custom-0 encryption instructions. Captures the
// instruction from decode, hands the command to the accelerator, waits for
// its result (with timeout), and writes the result back to the GPR file
// through the shared write port. Fetch/decode are frozen while busy.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   dec_*                           : decoded instruction and operand values
//   flush_i                         : pipeline flush, cancels the instruction
//   stall_o                         : freeze fetch and decode
//   acc_valid_o/acc_ready_i         : command handshake to the accelerator
//   acc_cmd_o, acc_op_a_o/b_o       : command {funct7,funct3} and operands
//   acc_done_i/acc_result_i         : one-cycle result pulse and data
//   wb_alu_*                        : normal pipeline writeback request
//   rf_*                            : GPR write port
//   err_o                           : one-cycle pulse on accelerator timeout
module crypto_issue_ctrl
    import crypto_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid_i,
    input  logic [6:0]            dec_op_i,
    input  logic [2:0]            dec_funct3_i,
    input  logic [6:0]            dec_funct7_i,
    input  logic [4:0]            dec_rd_i,
    input  logic [DATA_WIDTH-1:0] dec_rs1_val_i,
    input  logic [DATA_WIDTH-1:0] dec_rs2_val_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  acc_valid_o,
    input  logic                  acc_ready_i,
    output logic [CMD_W-1:0]      acc_cmd_o,
    output logic [DATA_WIDTH-1:0] acc_op_a_o,
    output logic [DATA_WIDTH-1:0] acc_op_b_o,
    input  logic                  acc_done_i,
    input  logic [DATA_WIDTH-1:0] acc_result_i,
    input  logic                  wb_alu_wen_i,
    input  logic [4:0]            wb_alu_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_alu_data_i,
    output logic                  rf_wen_o,
    output logic [4:0]            rf_write_sel_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  err_o
);

    // The counter starts at 0 on entry to WAIT, so the last permitted
    // WAIT cycle is the one where it holds TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] result;
    logic                  drop;
    logic [TO_W-1:0]       cnt;
    logic                  hit;
    logic                  timeout;
    logic                  acc_req;
    logic                  acc_grant;

    assign hit     = dec_valid_i & (dec_op_i == OPC_CUSTOM0) & ~flush_i;
    assign stall_o = (state == ST_IDLE) ? hit : 1'b1;
    assign timeout = (cnt == TO_LAST);
    // A flush in WB cancels the pending result write.
    assign acc_req = (state == ST_WB) & ~flush_i;

    crypto_wb_arb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wb_arb (
        .alu_wen   (wb_alu_wen_i),
        .alu_sel   (wb_alu_sel_i),
        .alu_data  (wb_alu_data_i),
        .acc_wen   (acc_req),
        .acc_sel   (rd),
        .acc_data  (result),
        .rf_wen    (rf_wen_o),
        .rf_sel    (rf_write_sel_o),
        .rf_data   (rf_wdata_o),
        .acc_grant (acc_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc_valid_o <= 1'b0;
            acc_cmd_o   <= '0;
            acc_op_a_o  <= '0;
            acc_op_b_o  <= '0;
            rd          <= '0;
            result      <= '0;
            drop        <= 1'b0;
            cnt         <= '0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                // acc_done_i is deliberately ignored here: a result that
                // arrives after a timeout must not reach the register file.
                ST_IDLE: begin
                    if (hit) begin
                        acc_cmd_o   <= {dec_funct7_i, dec_funct3_i};
                        acc_op_a_o  <= dec_rs1_val_i;
                        acc_op_b_o  <= dec_rs2_val_i;
                        rd          <= dec_rd_i;
                        drop        <= 1'b0;
                        acc_valid_o <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (acc_ready_i) begin
                        // Accepted: the accelerator will answer, so a
                        // simultaneous flush must wait for done and drop it.
                        acc_valid_o <= 1'b0;
                        cnt         <= '0;
                        drop        <= flush_i;
                        state       <= ST_WAIT;
                    end else if (flush_i) begin
                        acc_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (acc_done_i) begin
                        if (drop || flush_i || (rd == 5'd0)) begin
                            state <= ST_IDLE;
                        end else begin
                            result <= acc_result_i;
                            state  <= ST_WB;
                        end
                    end else if (timeout) begin
                        err_o <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                        if (flush_i) begin
                            drop <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    // Stay while the pipeline owns the write port.
                    if (flush_i || acc_grant) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_issue_ctrl.sv
// Testbench for crypto_issue_ctrl: reset checks, a table of directed
// transactions, hand-written reset/back-to-back sequences and randomized
// transactions judged by a transaction-level outcome model.
module tb_crypto_issue_ctrl;

    localparam int         DW      = 32;
    localparam int         TIMEOUT = 255;
    localparam logic [6:0] OPC     = 7'b0001011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid_i;
    logic [6:0]    dec_op_i;
    logic [2:0]    dec_funct3_i;
    logic [6:0]    dec_funct7_i;
    logic [4:0]    dec_rd_i;
    logic [DW-1:0] dec_rs1_val_i;
    logic [DW-1:0] dec_rs2_val_i;
    logic          flush_i;
    logic          stall_o;
    logic          acc_valid_o;
    logic          acc_ready_i;
    logic [9:0]    acc_cmd_o;
    logic [DW-1:0] acc_op_a_o;
    logic [DW-1:0] acc_op_b_o;
    logic          acc_done_i;
    logic [DW-1:0] acc_result_i;
    logic          wb_alu_wen_i;
    logic [4:0]    wb_alu_sel_i;
    logic [DW-1:0] wb_alu_data_i;
    logic          rf_wen_o;
    logic [4:0]    rf_write_sel_o;
    logic [DW-1:0] rf_wdata_o;
    logic          err_o;

    always #5 clk = ~clk;

    crypto_issue_ctrl #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_W           (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_valid_i    (dec_valid_i),
        .dec_op_i       (dec_op_i),
        .dec_funct3_i   (dec_funct3_i),
        .dec_funct7_i   (dec_funct7_i),
        .dec_rd_i       (dec_rd_i),
        .dec_rs1_val_i  (dec_rs1_val_i),
        .dec_rs2_val_i  (dec_rs2_val_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .acc_valid_o    (acc_valid_o),
        .acc_ready_i    (acc_ready_i),
        .acc_cmd_o      (acc_cmd_o),
        .acc_op_a_o     (acc_op_a_o),
        .acc_op_b_o     (acc_op_b_o),
        .acc_done_i     (acc_done_i),
        .acc_result_i   (acc_result_i),
        .wb_alu_wen_i   (wb_alu_wen_i),
        .wb_alu_sel_i   (wb_alu_sel_i),
        .wb_alu_data_i  (wb_alu_data_i),
        .rf_wen_o       (rf_wen_o),
        .rf_write_sel_o (rf_write_sel_o),
        .rf_wdata_o     (rf_wdata_o),
        .err_o          (err_o)
    );

    // One transaction: instruction word, operands, accelerator result and
    // the cycle schedule of handshakes/flushes, plus the expected outcome.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] res;
        int          ready_dly;     // ISSUE cycle index where ready rises
        int          done_dly;      // WAIT cycle index of done (>=255: never)
        int          flush_iss_at;  // ISSUE cycle index of flush, -1 none
        int          flush_wait_at; // WAIT cycle index of flush, -1 none
        int          alu_cycles;    // pipeline writes occupying WB first
        bit          flush_wb;      // flush on the first free WB cycle
        logic [9:0]  exp_cmd;
        int          exp_writes;
        bit          exp_err;
    } vec_t;

    int n_checks    = 0;
    int n_fail      = 0;
    int ctrl_writes = 0;

    // Any port write without a pipeline request belongs to the controller.
    always @(negedge clk) begin
        if (rf_wen_o && !wb_alu_wen_i) ctrl_writes++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        dec_valid_i   = 1'b0;
        dec_op_i      = '0;
        dec_funct3_i  = '0;
        dec_funct7_i  = '0;
        dec_rd_i      = '0;
        dec_rs1_val_i = '0;
        dec_rs2_val_i = '0;
        flush_i       = 1'b0;
        acc_ready_i   = 1'b0;
        acc_done_i    = 1'b0;
        acc_result_i  = '0;
        wb_alu_wen_i  = 1'b0;
        wb_alu_sel_i  = '0;
        wb_alu_data_i = '0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        dec_valid_i   = 1'b1;
        dec_op_i      = instr[6:0];
        dec_rd_i      = instr[11:7];
        dec_funct3_i  = instr[14:12];
        dec_funct7_i  = instr[31:25];
        dec_rs1_val_i = rs1;
        dec_rs2_val_i = rs2;
    endtask

    // Outcome from the instruction-level rules: a result is written only if
    // the command was accepted, never flushed, answered in time and has a
    // non-zero destination; a timeout of an accepted command raises err.
    function automatic void model(input vec_t t, output int writes, output bit err);
        bit issued, dropped, timed_out;
        issued    = (t.flush_iss_at < 0) || (t.flush_iss_at >= t.ready_dly);
        dropped   = (t.flush_iss_at == t.ready_dly) || (t.flush_wait_at >= 0);
        timed_out = (t.done_dly >= TIMEOUT);
        err       = issued && timed_out;
        writes    = (issued && !timed_out && !dropped && (t.instr[11:7] != 5'd0) && !t.flush_wb) ? 1 : 0;
    endfunction

    // Entered just after a rising edge with the controller idle.
    task automatic run_txn(input vec_t t, input string tag);
        int   w0;
        bit   aborted;
        bit   dropped;
        bit   done_seen;
        logic [4:0] dest;
        dest      = t.instr[11:7];
        aborted   = 1'b0;
        dropped   = 1'b0;
        done_seen = 1'b0;
        w0        = ctrl_writes;
        present(t.instr, t.rs1, t.rs2);
        @(negedge clk);
        check({tag, " detect stall/valid"}, {stall_o, acc_valid_o}, 2'b10);
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dec_rs1_val_i = $urandom;
            dec_rs2_val_i = $urandom;
            dec_funct3_i  = 3'($urandom);
            dec_funct7_i  = 7'($urandom);
            acc_ready_i   = (i >= t.ready_dly);
            flush_i       = (i == t.flush_iss_at);
            @(negedge clk);
            check({tag, " issue {valid,stall,cmd,a,b}"},
                  {acc_valid_o, stall_o, acc_cmd_o, acc_op_a_o, acc_op_b_o},
                  {2'b11, t.exp_cmd, t.rs1, t.rs2});
            @(posedge clk); #1;
            if (acc_ready_i) begin
                dropped = flush_i;
                break;
            end
            if (flush_i) begin
                aborted = 1'b1;
                break;
            end
        end
        acc_ready_i = 1'b0;
        flush_i     = 1'b0;
        if (!aborted) begin
            for (int j = 0; j < TIMEOUT; j++) begin
                acc_done_i    = (j == t.done_dly);
                acc_result_i  = acc_done_i ? t.res : $urandom;
                flush_i       = (j == t.flush_wait_at);
                wb_alu_wen_i  = ($urandom_range(3, 0) == 0);
                wb_alu_sel_i  = 5'($urandom);
                wb_alu_data_i = $urandom;
                @(negedge clk);
                check({tag, " wait {stall,valid,err}"}, {stall_o, acc_valid_o, err_o}, 3'b100);
                if (wb_alu_wen_i)
                    check({tag, " wait passthrough"}, {rf_wen_o, rf_write_sel_o, rf_wdata_o},
                          {1'b1, wb_alu_sel_i, wb_alu_data_i});
                else
                    check({tag, " wait rf_wen"}, rf_wen_o, 1'b0);
                @(posedge clk); #1;
                if (flush_i) dropped = 1'b1;
                if (acc_done_i) begin
                    done_seen = 1'b1;
                    break;
                end
            end
        end
        acc_done_i   = 1'b0;
        flush_i      = 1'b0;
        wb_alu_wen_i = 1'b0;
        if (done_seen && !dropped && dest != 5'd0) begin
            for (int k = 0; k < 8; k++) begin
                wb_alu_wen_i  = (k < t.alu_cycles);
                wb_alu_sel_i  = 5'd5;
                wb_alu_data_i = 32'h7;
                flush_i       = t.flush_wb && (k == t.alu_cycles);
                @(negedge clk);
                check({tag, " wb stall"}, stall_o, 1'b1);
                if (wb_alu_wen_i)
                    check({tag, " wb alu priority"}, {rf_wen_o, rf_write_sel_o, rf_wdata_o},
                          {1'b1, 5'd5, 32'h7});
                else if (flush_i)
                    check({tag, " wb flushed"}, rf_wen_o, 1'b0);
                else
                    check({tag, " wb acc write"}, {rf_wen_o, rf_write_sel_o, rf_wdata_o},
                          {1'b1, dest, t.res});
                @(posedge clk); #1;
                if (!wb_alu_wen_i) break;
            end
        end
        clear_inputs();
        // A done arriving after a timeout must be ignored.
        acc_done_i   = !done_seen && !aborted;
        acc_result_i = $urandom;
        @(negedge clk);
        check({tag, " end {stall,valid,err}"}, {stall_o, acc_valid_o, err_o}, {2'b00, t.exp_err});
        @(posedge clk); #1;
        acc_done_i = 1'b0;
        @(negedge clk);
        check({tag, " idle {stall,err}"}, {stall_o, err_o}, 2'b00);
        @(posedge clk); #1;
        check({tag, " controller writes"}, 128'(ctrl_writes - w0), 128'(t.exp_writes));
    endtask

    vec_t vecs[9];
    vec_t b2b;
    int   w_rst;

    initial begin
        // funct3 of 32'h0032408B is 3'b100, so its command is 10'h004.
        vecs[0] = '{32'h0032408B, 32'h1234, 32'h5678, 32'hDEADBEEF, 0, 4, -1, -1, 0, 1'b0, 10'h004, 1, 1'b0};
        vecs[1] = '{32'h0000000B, 32'h1, 32'h2, 32'hCAFEF00D, 1, 3, -1, -1, 0, 1'b0, 10'h000, 0, 1'b0};
        vecs[2] = '{32'h0000010B, 32'hAAAA, 32'hBBBB, 32'h1111, 3, 2, 1, -1, 0, 1'b0, 10'h000, 0, 1'b0};
        vecs[3] = '{32'h0000018B, 32'h3, 32'h4, 32'h2222, 1, 6, -1, 2, 0, 1'b0, 10'h000, 0, 1'b0};
        vecs[4] = '{32'h0000018B, 32'h5, 32'h6, 32'h3333, 0, 300, -1, -1, 0, 1'b0, 10'h000, 0, 1'b1};
        vecs[5] = '{32'h0000020B, 32'h7, 32'h8, 32'h44444444, 0, 2, -1, -1, 2, 1'b0, 10'h000, 1, 1'b0};
        vecs[6] = '{32'h0000020B, 32'h9, 32'hA, 32'h5555, 2, 3, 2, -1, 0, 1'b0, 10'h000, 0, 1'b0};
        vecs[7] = '{32'hFE007F8B, 32'hFFFFFFFF, 32'h80000000, 32'h6666, 1, 254, -1, -1, 0, 1'b0, 10'h3FF, 1, 1'b0};
        vecs[8] = '{32'h0000028B, 32'hB, 32'hC, 32'h7777, 0, 1, -1, -1, 1, 1'b1, 10'h000, 0, 1'b0};
        b2b     = '{32'hFE007F8B, 32'h1, 32'h2, 32'h3, 0, 0, -1, -1, 0, 1'b0, 10'h3FF, 1, 1'b0};

        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset outputs",
              {stall_o, acc_valid_o, err_o, rf_wen_o, acc_cmd_o, acc_op_a_o, acc_op_b_o}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 9; n++) run_txn(vecs[n], $sformatf("vec%0d", n));

        // Back-to-back: the next instruction is presented on the first idle cycle.
        present(32'h0000008B, 32'h11, 32'h22);
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        acc_ready_i = 1'b1;
        @(posedge clk); #1;
        acc_ready_i  = 1'b0;
        acc_done_i   = 1'b1;
        acc_result_i = 32'hA5A5A5A5;
        @(posedge clk); #1;
        acc_done_i = 1'b0;
        @(negedge clk);
        check("b2b first write", {rf_wen_o, rf_write_sel_o, rf_wdata_o}, {1'b1, 5'd1, 32'hA5A5A5A5});
        @(posedge clk); #1;
        run_txn(b2b, "b2b second");

        // Asynchronous reset while waiting for the accelerator.
        w_rst = ctrl_writes;
        present(32'hFE007F8B, 32'hFFFF0000, 32'h0000FFFF);
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        acc_ready_i = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset in wait",
              {stall_o, acc_valid_o, err_o, rf_wen_o, rf_write_sel_o, rf_wdata_o, acc_cmd_o, acc_op_a_o, acc_op_b_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        acc_done_i   = 1'b1;
        acc_result_i = 32'h99999999;
        @(negedge clk);
        check("post-reset idle", {stall_o, acc_valid_o, rf_wen_o}, 3'b000);
        @(posedge clk); #1;
        acc_done_i = 1'b0;
        @(negedge clk);
        check("post-reset still idle", {stall_o, rf_wen_o}, 2'b00);
        @(posedge clk); #1;
        check("post-reset no write", 128'(ctrl_writes - w_rst), 128'(0));
        run_txn(vecs[0], "after reset");

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            logic [4:0] rd;
            logic [2:0] f3;
            logic [6:0] f7;
            rd = 5'($urandom);
            if ($urandom_range(5, 0) == 0) rd = 5'd0;
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            v.instr = {f7, 5'($urandom), 5'($urandom), f3, rd, OPC};
            v.rs1   = $urandom;
            v.rs2   = $urandom;
            v.res   = $urandom;
            v.ready_dly = int'($urandom_range(3, 0));
            if ($urandom_range(4, 0) == 0) v.flush_iss_at = int'($urandom_range(v.ready_dly, 0));
            else v.flush_iss_at = -1;
            if ($urandom_range(19, 0) == 0) v.done_dly = 300;
            else v.done_dly = int'($urandom_range(8, 0));
            if (v.done_dly > 0 && v.done_dly < TIMEOUT && $urandom_range(4, 0) == 0)
                v.flush_wait_at = int'($urandom_range(v.done_dly - 1, 0));
            else
                v.flush_wait_at = -1;
            v.alu_cycles = int'($urandom_range(2, 0));
            v.flush_wb   = ($urandom_range(9, 0) == 0);
            v.exp_cmd    = {f7, f3};
            model(v, v.exp_writes, v.exp_err);
            run_txn(v, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
